mux4_rr_arbiter: RTL

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_arb_pkg.sv | 21 ++
 rtl/rr_pick4.sv | 39 +++
 rtl/mux4_rr_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mux4_arb_pkg.sv
// ============================================================================
// Module  : mux4_arb_pkg
// Purpose : Shared types and sizes for the 4-way round-robin mux arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int HOLD_W  = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
// Module  : rr_pick4
// Purpose : Combinational round-robin picker: first set request at or after
//           the pointer, returned as one-hot and as index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_any
);

  logic [SEL_W-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // 2-bit addition wraps naturally, giving the modulo-4 search order
      w_idx = i_ptr + SEL_W'(k);
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_idx        = w_idx;
        o_gnt[w_idx] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// Module  : mux4_rr_arbiter
// Purpose : Round-robin arbiter for a shared 4:1 mux path with registered
//           grant/select and a one-cycle registered datapath.
//           Define MUX4_ARB_LOCK_EN to enable LOCK-based grant holding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
)
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               LOCK,
  input  logic [NUM_REQ-1:0] D,
  output logic [NUM_REQ-1:0] GNT,
  output logic [SEL_W-1:0]   SEL,
  output logic               Y,
  output logic               VALID
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [SEL_W-1:0]   ptr_q,   ptr_d;
  logic               y_q,     y_d;
  logic               valid_q, valid_d;

  logic [NUM_REQ-1:0] w_win_gnt;
  logic [SEL_W-1:0]   w_win_idx;
  logic               w_win_any;
  logic               w_extend;

  rr_pick4 u_pick (
    .i_req (REQ),
    .i_ptr (ptr_q),
    .o_gnt (w_win_gnt),
    .o_idx (w_win_idx),
    .o_any (w_win_any)
  );

`ifdef MUX4_ARB_LOCK_EN
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Extension only while below the limit, so the counter saturates at MAX_HOLD
  assign w_extend = (state_q == BUSY) && LOCK && REQ[sel_q] &&
                    (hold_q < HOLD_W'(MAX_HOLD));

  always_comb begin
    hold_d = hold_q;
    if (w_extend) begin
      hold_d = hold_q + HOLD_W'(1);
    end else if (w_win_any) begin
      hold_d = HOLD_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = LOCK ^ (MAX_HOLD == 0);
  assign w_extend     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (w_extend) begin
      state_d = BUSY;
    end else if (w_win_any) begin
      // Pointer already sits past the grantee, so it is searched last
      state_d = BUSY;
      gnt_d   = w_win_gnt;
      sel_d   = w_win_idx;
      ptr_d   = w_win_idx + SEL_W'(1);
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
    end
  end

  always_comb begin
    valid_d = (state_q == BUSY);
    y_d     = valid_d ? D[sel_q] : y_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign GNT   = gnt_q;
  assign SEL   = sel_q;
  assign Y     = y_q;
  assign VALID = valid_q;

endmodule

`default_nettype wire
